// File: rtl/comma_align_pkg.sv
// comma_align shared types and constants.
// Symbol width, comma patterns, aligner FSM states.
package comma_align_pkg;

    localparam int SYM_W = 10;

    localparam logic [6:0] COMMA_NEG = 7'b1111100;
    localparam logic [6:0] COMMA_POS = 7'b0000011;

    typedef enum logic [1:0] {
        HUNT,
        VERIFY,
        LOCKED
    } state_t;

endpackage

// File: rtl/comma_align_if.sv
// Deserializer-side and decoder-side signals of the aligner.
// master drives raw words and error feedback, slave is the aligner.
interface comma_align_if;
    import comma_align_pkg::*;

    logic [SYM_W-1:0] rx_data;
    logic             rx_valid;
    logic             rx_err;
    logic [SYM_W-1:0] out_data;
    logic             out_valid;
    logic             out_comma;
    logic             locked;
    logic [3:0]       align_offset;

    modport master (
        output rx_data, rx_valid, rx_err,
        input  out_data, out_valid, out_comma,
        input  locked, align_offset
    );

    modport slave (
        input  rx_data, rx_valid, rx_err,
        output out_data, out_valid, out_comma,
        output locked, align_offset
    );

endinterface

// File: rtl/comma_align_detect.sv
// Comma search over all ten candidate offsets of a 20-bit window.
// Lowest matching offset wins when several hit.
module comma_detect
    import comma_align_pkg::*;
(
    input  logic [2*SYM_W-1:0] win,
    output logic [SYM_W-1:0]   hit,
    output logic [3:0]         idx
);

    logic unused_hi;
    assign unused_hi = ^win[2*SYM_W-1:16];

    // Match bits [6:0] of each candidate, then pick the lowest hit
    always_comb begin
        hit = '0;
        idx = '0;
        for (int k = 0; k < SYM_W; k++) begin
            hit[k] = (win[k +: 7] == COMMA_NEG) ||
                     (win[k +: 7] == COMMA_POS);
        end
        for (int k = SYM_W - 1; k >= 0; k--) begin
            if (hit[k]) idx = 4'(k);
        end
    end

endmodule

// File: rtl/comma_align.sv
// Word aligner ahead of the 8b/10b decoder.
// Hunts for commas, locks on a bit offset, drops lock on error runs.
module comma_align
    import comma_align_pkg::*;
#(
    parameter int LOCK_COUNT = 4,
    parameter int LOSS_COUNT = 4
) (
    input logic          clk,
    input logic          rst,
    comma_align_if.slave bus
);

    localparam logic [3:0] LOCK_N = 4'(LOCK_COUNT);
    localparam logic [3:0] LOSS_N = 4'(LOSS_COUNT);

    state_t           state, state_nxt;
    logic [SYM_W-1:0] prev;
    logic             primed;
    logic [3:0]       off, off_nxt;
    logic [3:0]       cnt, cnt_nxt;
    logic [3:0]       errcnt, errcnt_nxt;
    logic [3:0]       cnt_inc, errcnt_inc;
    logic [2*SYM_W-1:0] win;
    logic [SYM_W-1:0] hit;
    logic [3:0]       hit_idx;
    logic             any_hit, cur_hit, err_s;
    logic [SYM_W-1:0] out_sel;
    logic             comma_sel;
    logic [SYM_W-1:0] out_data_q;
    logic             out_valid_q, out_comma_q;

    assign win        = {bus.rx_data, prev};
    assign any_hit    = |hit;
    assign cur_hit    = hit[off];
    assign err_s      = bus.rx_err & out_valid_q;
    assign cnt_inc    = cnt + 4'd1;
    assign errcnt_inc = errcnt + 4'd1;

    comma_detect u_detect (
        .win (win),
        .hit (hit),
        .idx (hit_idx)
    );

    // Next state, offset and counters; error beats a same-cycle hit
    always_comb begin
        state_nxt  = state;
        off_nxt    = off;
        cnt_nxt    = cnt;
        errcnt_nxt = errcnt;
        unique case (state)
            HUNT: begin
                if (any_hit) begin
                    off_nxt   = hit_idx;
                    cnt_nxt   = 4'd1;
                    state_nxt = (LOCK_N == 4'd1) ? LOCKED : VERIFY;
                end
            end
            VERIFY: begin
                if (err_s) begin
                    state_nxt = HUNT;
                    cnt_nxt   = '0;
                end else if (cur_hit) begin
                    cnt_nxt = cnt_inc;
                    if (cnt_inc >= LOCK_N) state_nxt = LOCKED;
                end else if (any_hit) begin
                    off_nxt = hit_idx;
                    cnt_nxt = 4'd1;
                end
            end
            LOCKED: begin
                if (err_s) begin
                    errcnt_nxt = errcnt_inc;
                    if (errcnt_inc >= LOSS_N) begin
                        state_nxt  = HUNT;
                        errcnt_nxt = '0;
                        cnt_nxt    = '0;
                    end
                end else begin
                    errcnt_nxt = '0;
                end
            end
            default: state_nxt = HUNT;
        endcase
        out_sel   = win[{1'b0, off_nxt} +: SYM_W];
        comma_sel = hit[off_nxt];
    end

    // Registers advance only on valid words; first word only primes
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= HUNT;
            prev        <= '0;
            primed      <= 1'b0;
            off         <= '0;
            cnt         <= '0;
            errcnt      <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_comma_q <= 1'b0;
        end else if (bus.rx_valid) begin
            prev <= bus.rx_data;
            if (!primed) begin
                primed      <= 1'b1;
                out_valid_q <= 1'b0;
            end else begin
                state       <= state_nxt;
                off         <= off_nxt;
                cnt         <= cnt_nxt;
                errcnt      <= errcnt_nxt;
                out_data_q  <= out_sel;
                out_comma_q <= comma_sel;
                out_valid_q <= 1'b1;
            end
        end else begin
            out_valid_q <= 1'b0;
        end
    end

    assign bus.out_data     = out_data_q;
    assign bus.out_valid    = out_valid_q;
    assign bus.out_comma    = out_comma_q;
    assign bus.locked       = (state == LOCKED);
    assign bus.align_offset = off;

endmodule

// File: tb/tb_comma_align.sv
// Bench for comma_align: directed scenarios plus random bit streams,
// all compared against a serial-stream reference model.
module tb_comma_align;

    localparam int LC = 4;
    localparam int LS = 4;
    localparam int M_HUNT   = 0;
    localparam int M_VERIFY = 1;
    localparam int M_LOCKED = 2;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    comma_align_if bus ();

    comma_align #(
        .LOCK_COUNT (LC),
        .LOSS_COUNT (LS)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    bit sq[$];
    bit alt;

    logic [9:0] m_prev;
    bit         m_primed;
    int         m_mode;
    int         m_off;
    int         m_cnt;
    int         m_errs;
    logic [9:0] m_data;
    bit         m_valid;
    bit         m_comma;

    function automatic bit is_comma(logic [19:0] w, int k);
        logic [19:0] s;
        s = w >> k;
        return (s[6:0] == 7'b1111100) || (s[6:0] == 7'b0000011);
    endfunction

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_prev = '0; m_primed = 0; m_mode = M_HUNT;
        m_off = 0; m_cnt = 0; m_errs = 0;
        m_data = '0; m_valid = 0; m_comma = 0;
        sq.delete();
        alt = 0;
    endtask

    task automatic model_step(logic [9:0] d, bit v, bit e);
        logic [19:0] w;
        int low;
        bit err_s;
        if (!v) begin
            m_valid = 0;
            return;
        end
        if (!m_primed) begin
            m_prev = d; m_primed = 1; m_valid = 0;
            return;
        end
        w = {d, m_prev};
        low = -1;
        for (int k = 9; k >= 0; k--) if (is_comma(w, k)) low = k;
        err_s = e && m_valid;
        case (m_mode)
            M_HUNT: if (low >= 0) begin
                m_off = low; m_cnt = 1;
                m_mode = (LC == 1) ? M_LOCKED : M_VERIFY;
            end
            M_VERIFY: if (err_s) begin
                m_mode = M_HUNT; m_cnt = 0;
            end else if (is_comma(w, m_off)) begin
                m_cnt++;
                if (m_cnt >= LC) m_mode = M_LOCKED;
            end else if (low >= 0) begin
                m_off = low; m_cnt = 1;
            end
            default: if (err_s) begin
                m_errs++;
                if (m_errs >= LS) begin
                    m_mode = M_HUNT; m_errs = 0;
                end
            end else begin
                m_errs = 0;
            end
        endcase
        m_data  = 10'(w >> m_off);
        m_comma = is_comma(w, m_off);
        m_valid = 1;
        m_prev  = d;
    endtask

    task automatic step(logic [9:0] d, bit v, bit e);
        bus.rx_data  = d;
        bus.rx_valid = v;
        bus.rx_err   = e;
        model_step(d, v, e);
        @(posedge clk);
        #1;
        check("out_valid", 32'(bus.out_valid), 32'(m_valid));
        check("locked", 32'(bus.locked), 32'(m_mode == M_LOCKED));
        check("align_offset", 32'(bus.align_offset), 32'(m_off));
        check("out_data", 32'(bus.out_data), 32'(m_data));
        check("out_comma", 32'(bus.out_comma), 32'(m_comma));
    endtask

    task automatic push_sym(logic [9:0] s);
        for (int i = 0; i < 10; i++) sq.push_back(s[i]);
    endtask

    task automatic push_bits(int n, bit rnd);
        for (int i = 0; i < n; i++) sq.push_back(rnd ? 1'($urandom) : 1'b0);
    endtask

    task automatic push_comma();
        push_sym(alt ? 10'h283 : 10'h17C);
        alt = ~alt;
    endtask

    task automatic send_ready(bit e);
        logic [9:0] w;
        while (sq.size() >= 10) begin
            for (int i = 0; i < 10; i++) w[i] = sq.pop_front();
            step(w, 1'b1, e);
        end
    endtask

    task automatic comma_run(int n, bit e);
        for (int i = 0; i < n; i++) begin
            push_comma();
            send_ready(e);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_locked", 32'(bus.locked), 32'd0);
        check("rst_offset", 32'(bus.align_offset), 32'd0);
        check("rst_out_data", 32'(bus.out_data), 32'd0);
        check("rst_out_comma", 32'(bus.out_comma), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        bit gap;
        logic [9:0] w;
        rst = 1'b1;
        bus.rx_data  = '0;
        bus.rx_valid = 1'b0;
        bus.rx_err   = 1'b0;
        model_reset();
        #12;
        do_reset();

        // aligned K28.5 stream at offset 0
        for (int i = 0; i < 4; i++) step(10'h17C, 1'b1, 1'b0);
        check("aligned_pre_lock", 32'(bus.locked), 32'd0);
        step(10'h17C, 1'b1, 1'b0);
        check("aligned_lock", 32'(bus.locked), 32'd1);
        check("aligned_offset", 32'(bus.align_offset), 32'd0);
        check("aligned_data", 32'(bus.out_data), 32'h17C);
        check("aligned_comma", 32'(bus.out_comma), 32'd1);

        // alternating commas delayed by 3 bits
        do_reset();
        push_bits(3, 1'b0);
        comma_run(2, 1'b0);
        check("shift_offset", 32'(bus.align_offset), 32'd3);
        comma_run(3, 1'b0);
        check("shift_lock", 32'(bus.locked), 32'd1);
        check("shift_offset_lk", 32'(bus.align_offset), 32'd3);

        // re-target from offset 3 to offset 7
        do_reset();
        push_bits(3, 1'b0);
        comma_run(3, 1'b0);
        check("rt_first_off", 32'(bus.align_offset), 32'd3);
        check("rt_not_locked", 32'(bus.locked), 32'd0);
        push_bits(4, 1'b0);
        comma_run(6, 1'b0);
        check("rt_offset", 32'(bus.align_offset), 32'd7);
        check("rt_lock", 32'(bus.locked), 32'd1);

        // error runs while locked
        comma_run(3, 1'b1);
        comma_run(1, 1'b0);
        comma_run(3, 1'b1);
        check("loss_hold", 32'(bus.locked), 32'd1);
        comma_run(1, 1'b0);
        comma_run(3, 1'b1);
        check("loss_3err", 32'(bus.locked), 32'd1);
        comma_run(1, 1'b1);
        check("loss_drop", 32'(bus.locked), 32'd0);

        // gaps while locked, then reset mid-lock
        do_reset();
        for (int i = 0; i < 5; i++) step(10'h17C, 1'b1, 1'b0);
        for (int i = 0; i < 6; i++) begin
            step(10'h17C, 1'b1, 1'b0);
            step(10'($urandom), 1'b0, 1'b1);
            check("gap_valid", 32'(bus.out_valid), 32'd0);
        end
        check("gap_lock", 32'(bus.locked), 32'd1);
        do_reset();
        step(10'h17C, 1'b1, 1'b0);
        check("reprime_valid", 32'(bus.out_valid), 32'd0);
        step(10'h17C, 1'b1, 1'b0);
        check("reprime_valid2", 32'(bus.out_valid), 32'd1);

        // random streams with slips, gaps and decoder errors
        do_reset();
        for (int n = 0; n < 500; n++) begin
            if ($urandom_range(0, 99) < 5) push_bits($urandom_range(1, 9), 1'b1);
            if ($urandom_range(0, 99) < 70) push_comma();
            else push_sym(10'($urandom));
            while (sq.size() >= 10) begin
                for (int i = 0; i < 10; i++) w[i] = sq.pop_front();
                gap = ($urandom_range(0, 9) < 2);
                if (gap) step(10'($urandom), 1'b0, 1'($urandom));
                step(w, 1'b1, ($urandom_range(0, 99) < 15));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/comma_align.md
# comma_align

Word aligner sitting directly upstream of the 8b/10b `decode` stage. It takes unaligned 10-bit words from the deserializer and searches a 20-bit window for the comma sequence. It locks onto a bit offset after repeated commas at that offset and presents aligned 10-bit symbols to the decoder. It drops lock when the decoder's error feedback shows a run of bad symbols.

## Interface
Parameters:
- `LOCK_COUNT`, default 4: commas at one offset needed to declare lock. Legal range 1..15.
- `LOSS_COUNT`, default 4: consecutive errored symbols that drop lock. Legal range 1..15.

Ports:
- `clk`, input, 1: sole clock; all state changes on the rising edge.
- `rst`, input, 1: asynchronous, active-high reset.
- `rx_data`, input, 10: raw deserializer word. Bit 0 is the earliest-received bit, so it maps to decoder bit `a`.
- `rx_valid`, input, 1: `rx_data` is valid this cycle.
- `rx_err`, input, 1: `code_err | disp_err` from the downstream decoder for the current `out_data`. Sampled only when `out_valid` = 1.
- `out_data`, output, 10: aligned symbol, bit order `a b c d e i f g h j` from bit 0 upward.
- `out_valid`, output, 1: `out_data` is valid.
- `out_comma`, output, 1: `out_data` contains a comma.
- `locked`, output, 1: alignment is locked.
- `align_offset`, output, 4: current bit offset, 0..9.

## Operation
- **Window:** `win[19:0] = {rx_data, prev}`, where `prev` holds the previous valid `rx_data`. The candidate at offset k is `win[k+9:k]`, for k = 0..9.
- **Comma detect:** a candidate's bits [6:0] equal 7'b1111100 (RD−, a..f = 0011111) or 7'b0000011 (RD+). This yields a 10-bit hit vector. When several offsets hit, the lowest offset wins.
- **Qualification:** all window and FSM activity is qualified by `rx_valid`. With `rx_valid` = 0:
  - nothing updates;
  - `out_valid` = 0 on the next cycle;
  - `out_data` and `out_comma` hold.
- **Priming:** the first valid word after reset only loads `prev`. `out_valid` first asserts on the cycle after the second valid word.
- **FSM, three states: HUNT, VERIFY, LOCKED.**
  - **HUNT:**
    - A hit at any offset k sets `align_offset` = k and cnt = 1.
    - Next state is VERIFY, or LOCKED directly if `LOCK_COUNT` = 1.
    - With no hit, the offset is held.
  - **VERIFY:**
    - A hit at the current offset increments cnt. When cnt reaches `LOCK_COUNT`, go to LOCKED.
    - A hit only at other offsets re-targets: offset = lowest hit, cnt = 1.
    - A sampled `rx_err` = 1 returns to HUNT with cnt = 0.
  - **LOCKED:**
    - The offset is frozen. Hits at other offsets are ignored.
    - A sampled `rx_err` increments errcnt. A sampled `rx_err` = 0 clears errcnt.
    - When errcnt reaches `LOSS_COUNT`, go to HUNT and clear errcnt. `locked` falls on the same edge.
  - **Simultaneous events:** a sampled `rx_err` takes priority over a same-cycle comma hit in VERIFY and LOCKED.
- **Output:** `out_data` is the window at the offset in effect after this cycle's update. The comma that triggers a re-target is therefore itself emitted, with `out_comma` = 1.
- **Decoder feed:** `out_data` is produced in every state, including HUNT, so the decoder always sees data.

## Timing
- Latency is 1 cycle from a valid `rx_data` edge to `out_data` / `out_valid`.
- `locked` is registered and rises on the edge that registers the `LOCK_COUNT`-th comma.
- `rx_err` is combinational from the decoder, valid in the same cycle as `out_data`.
- **Reset values:** `out_data` = 0, `out_valid` = 0, `out_comma` = 0, `locked` = 0, `align_offset` = 0. Internally: state = HUNT, cnt = 0, errcnt = 0, `prev` = 0, primed = 0.
- Reset mid-lock takes effect immediately; re-priming is then required.
- Counters saturate and never wrap: cnt is bounded by `LOCK_COUNT`, errcnt by `LOSS_COUNT`.

## Structure
- Package `comma_align_pkg` holds:
  - the state enum (HUNT/VERIFY/LOCKED);
  - `SYM_W` = 10;
  - `COMMA_NEG` = 7'b1111100 and `COMMA_POS` = 7'b0000011.
- Sub-module `comma_detect`: combinational, 20-bit window in, 10-bit hit vector plus lowest-hit index out.
- The FSM, counters and output register live in the top level.

## Test plan
- **Aligned lock:** K28.5 RD− word 10'h17C repeated at offset 0 -> `align_offset` = 0; `locked` rises on the edge registering the 4th comma; `out_data` = 10'h17C with `out_comma` = 1.
- **Shifted stream:** alternating 10'h17C / 10'h283 delayed by 3 bits -> `align_offset` = 3 after the first comma; `out_data` alternates 10'h17C / 10'h283; lock after 4 commas.
- **Re-target in VERIFY:** 2 commas at offset 3, then commas at offset 7 -> offset becomes 7, cnt restarts, lock after 4 commas at offset 7.
- **Loss of lock:** once locked, force `rx_err` = 1 on 4 consecutive valid outputs -> `locked` = 0 and state HUNT. With 3 errors, then 1 good symbol, then 3 errors, `locked` stays 1.
- **Gaps and reset:** `rx_valid` toggled 1/0 keeps state and gives `out_valid` = 0 on gap cycles. `rst` pulsed while locked -> all outputs 0 immediately, and the first post-reset valid word produces no `out_valid`.
